// File: rtl/priority_encoder_reg.sv
// Registered leading-one encoder: turns an 11-bit magnitude into the 3-bit
// floating-point exponent, one cycle of latency, with a valid flag.
module priority_encoder_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [10:0] in,
  output logic [2:0]  out,
  output logic        out_valid
);

  logic [2:0] exp_next;

  // Ascending scan so the highest set bit in [10:4] wins; bits [3:0] map to 0.
  always_comb begin
    exp_next = 3'd0;
    for (int i = 4; i <= 10; i++) begin
      if (in[i]) exp_next = 3'(i - 3);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= exp_next;
    end
  end

endmodule

// File: tb/tb_priority_encoder_reg.sv
// Self-checking bench for priority_encoder_reg: directed cases plus random and
// exhaustive sweeps against a log2-based reference model.
module tb_priority_encoder_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [10:0] in = '0;
  logic [2:0]  out;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  logic [2:0] mo = 3'd0;
  logic       mv = 1'b0;

  priority_encoder_reg dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in(in),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Exponent = floor(log2(v)) - 3, clamped at 0 (v = 0 also gives 0).
  function automatic logic [2:0] golden_exp(input logic [10:0] v);
    int p = -1;
    int x = int'(v);
    while (x > 0) begin
      x = x / 2;
      p++;
    end
    return (p >= 4) ? 3'(p - 3) : 3'd0;
  endfunction

  // Drive between edges, advance one rising edge, update the model.
  task automatic step(input logic v, input logic [10:0] d);
    @(negedge clk);
    in_valid = v;
    in = d;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      mo = 3'd0;
      mv = 1'b0;
    end else begin
      mv = v;
      if (v) mo = golden_exp(d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    in = 11'h7FF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (out !== 3'd0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold out=%0d valid=%b want out=0 valid=0", out, out_valid);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    mo = 3'd0;
    mv = 1'b0;
    step(1'b1, 11'h7FF);
    total++;
    if (out !== 3'd7 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_first out=%0d valid=%b want out=7 valid=1", out, out_valid);
    end
  endtask

  task automatic test_single_hot();
    logic [2:0] want [11];
    logic [10:0] d;
    want = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    for (int k = 0; k < 11; k++) begin
      d = 11'd1 << k;
      step(1'b1, d);
      total++;
      if (out !== want[k] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL single_hot k=%0d out=%0d valid=%b want out=%0d valid=1",
                 k, out, out_valid, want[k]);
      end
    end
  endtask

  task automatic test_corners();
    logic [10:0] vals [8];
    logic [2:0]  want [8];
    vals = '{11'h000, 11'h00F, 11'h010, 11'h01F, 11'h7FF, 11'h421, 11'h0FF, 11'h3C0};
    want = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd7, 3'd7, 3'd4, 3'd6};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vals[i]);
      total++;
      if (out !== want[i] || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL corner in=%h out=%0d valid=%b want out=%0d valid=1",
                 vals[i], out, out_valid, want[i]);
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, 11'h100);
    total++;
    if (out !== 3'd5 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_load out=%0d valid=%b want out=5 valid=1", out, out_valid);
    end
    step(1'b0, 11'h7FF);
    total++;
    if (out !== 3'd5 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL hold_idle out=%0d valid=%b want out=5 valid=0", out, out_valid);
    end
    step(1'b1, 11'h020);
    total++;
    if (out !== 3'd2 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL hold_next out=%0d valid=%b want out=2 valid=1", out, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic v;
    logic [10:0] d;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = 11'($urandom >> $urandom_range(0, 30));
      step(v, d);
      total++;
      if (out !== mo || out_valid !== mv) begin
        bad++;
        $display("FAIL random i=%0d in=%h v=%b out=%0d valid=%b want out=%0d valid=%b",
                 i, d, v, out, out_valid, mo, mv);
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 11'h400);
    step(1'b1, 11'h200);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid out=%0d valid=%b want out=0 valid=0", out, out_valid);
    end
    step(1'b1, 11'h7FF);
    total++;
    if (out !== 3'd0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_edge out=%0d valid=%b want out=0 valid=0", out, out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 2048; n++) begin
      step(1'b1, 11'(n));
      total++;
      if (out !== mo || out_valid !== 1'b1) begin
        bad++;
        $display("FAIL sweep in=%h out=%0d valid=%b want out=%0d valid=1",
                 11'(n), out, out_valid, mo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_hot();
    test_corners();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
